req_capture4: RTL and testbench

Four-line request capture stage sitting directly upstream of the 4-to-2 priority encoder. It synchronises four asynchronous request lines, detects rising edges, and holds each event as a sticky pending bit until the consumer acknowledges it by encoded index. The masked pending vector drives the encoder's 4-bit input, and `irq` summarises it. Lost events (an edge arriving on an already-pending line) are flagged per line.

---
 rtl/req_pkg.sv | 6 +
 rtl/sync_edge_det.sv | 21 ++
 rtl/req_capture4.sv | 42 ++++
 tb/tb_req_capture4.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/req_pkg.sv
// req_pkg: shared request-vector types and sizes for the capture stage and encoder wrapper
package req_pkg;
  localparam int NUM_REQ = 4;
  localparam int IDX_W = 2;
  typedef logic [NUM_REQ-1:0] req_vec_t;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchroniser plus history flop producing a one-cycle rising-edge pulse
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync;
  logic hist;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      hist <= sync[SYNC_STAGES-1];
    end
  assign rise = sync[SYNC_STAGES-1] & ~hist;
endmodule

// File: rtl/req_capture4.sv
// req_capture4: captures rising edges on four async request lines as sticky, maskable pending bits
module req_capture4
  import req_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  req_vec_t         req_in,
  input  logic             mask_wr,
  input  req_vec_t         mask_din,
  input  logic             ack,
  input  logic [IDX_W-1:0] ack_idx,
  input  logic             clr_overrun,
  output req_vec_t         pending,
  output logic             irq,
  output req_vec_t         overrun,
  output logic             ack_err
);
  req_vec_t rise, raw_pend, mask, ack_hit;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_sync
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk), .rst(rst), .din(req_in[i]), .rise(rise[i])
    );
  end
  // an ack on a non-pending line clears nothing, so it needs no extra gating
  assign ack_hit = ack ? req_vec_t'(1) << ack_idx : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      raw_pend <= '0;
      mask     <= '0;
      overrun  <= '0;
      ack_err  <= 1'b0;
    end else begin
      raw_pend <= rise | (raw_pend & ~ack_hit);
      overrun  <= (rise & raw_pend & ~ack_hit) | (clr_overrun ? '0 : overrun);
      mask     <= mask_wr ? mask_din : mask;
      ack_err  <= ack & ~raw_pend[ack_idx];
    end
  assign pending = raw_pend & ~mask;
  assign irq = |pending;
endmodule

// File: tb/tb_req_capture4.sv
// tb_req_capture4: directed plus random checks of both synchroniser depths against a delay-line model
module tb_req_capture4;
  import req_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  req_vec_t req_in = '0, mask_din = '0;
  logic mask_wr = 1'b0, ack = 1'b0, clr_overrun = 1'b0;
  logic [IDX_W-1:0] ack_idx = '0;
  req_vec_t pend_a, ovr_a, pend_b, ovr_b;
  logic irq_a, err_a, irq_b, err_b;
  int ncmp = 0, nfail = 0;
  // model: per-depth sample history (newest first), pending/overrun/ack_err, shared mask
  logic [3:0] q2[$], q3[$];
  logic [3:0] m_pend[2], m_ovr[2], m_msk;
  logic m_err[2];

  always #5 clk = ~clk;

  req_capture4 #(.SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .req_in(req_in), .mask_wr(mask_wr), .mask_din(mask_din),
    .ack(ack), .ack_idx(ack_idx), .clr_overrun(clr_overrun),
    .pending(pend_a), .irq(irq_a), .overrun(ovr_a), .ack_err(err_a)
  );
  req_capture4 #(.SYNC_STAGES(3)) dut3 (
    .clk(clk), .rst(rst), .req_in(req_in), .mask_wr(mask_wr), .mask_din(mask_din),
    .ack(ack), .ack_idx(ack_idx), .clr_overrun(clr_overrun),
    .pending(pend_b), .irq(irq_b), .overrun(ovr_b), .ack_err(err_b)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q2 = {4'h0, 4'h0, 4'h0};
    q3 = {4'h0, 4'h0, 4'h0, 4'h0};
    m_msk = '0;
    for (int d = 0; d < 2; d++) begin
      m_pend[d] = '0;
      m_ovr[d] = '0;
      m_err[d] = 1'b0;
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_pend2"}, 8'(pend_a), 8'(m_pend[0] & ~m_msk));
    chk({tag, "_irq2"}, 8'(irq_a), 8'(|(m_pend[0] & ~m_msk)));
    chk({tag, "_ovr2"}, 8'(ovr_a), 8'(m_ovr[0]));
    chk({tag, "_err2"}, 8'(err_a), 8'(m_err[0]));
    chk({tag, "_pend3"}, 8'(pend_b), 8'(m_pend[1] & ~m_msk));
    chk({tag, "_irq3"}, 8'(irq_b), 8'(|(m_pend[1] & ~m_msk)));
    chk({tag, "_ovr3"}, 8'(ovr_b), 8'(m_ovr[1]));
    chk({tag, "_err3"}, 8'(err_b), 8'(m_err[1]));
  endtask

  // one clock: an event is seen when the sample SYNC_STAGES edges old is 1 and the one before it 0
  task automatic step(input string tag = "step");
    logic [3:0] ev[2], np[2], no[2], ah, smp;
    logic ne[2];
    ev[0] = q2[1] & ~q2[2];
    ev[1] = q3[2] & ~q3[3];
    ah = ack ? (4'b0001 << ack_idx) : 4'b0000;
    for (int d = 0; d < 2; d++) begin
      ne[d] = ack && !m_pend[d][ack_idx];
      np[d] = ev[d] | (m_pend[d] & ~ah);
      no[d] = (ev[d] & m_pend[d] & ~ah) | (clr_overrun ? 4'b0000 : m_ovr[d]);
    end
    smp = req_in;
    @(posedge clk);
    if (mask_wr) m_msk = mask_din;
    for (int d = 0; d < 2; d++) begin
      m_pend[d] = np[d];
      m_ovr[d] = no[d];
      m_err[d] = ne[d];
    end
    q2.push_front(smp); void'(q2.pop_back());
    q3.push_front(smp); void'(q3.pop_back());
    #1;
    chk_all(tag);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_ack(input logic [1:0] idx);
    ack = 1'b1; ack_idx = idx;
    step("ack");
    ack = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_pend", 8'(pend_a), 8'h00);
    chk("rst_irq", 8'(irq_a), 8'h00);
    chk_all("rst");
    // capture latency: depth 2 after 3 edges, depth 3 one edge later
    req_in = 4'b0100;
    steps(2);
    chk("lat2_early", 8'(pend_a), 8'h00);
    step();
    chk("lat2", 8'(pend_a), 8'h04);
    chk("lat3_early", 8'(pend_b), 8'h00);
    step();
    chk("lat3", 8'(pend_b), 8'h04);
    steps(1);
    req_in = 4'b0000;
    do_ack(2'd2);
    chk("ack2_pend", 8'(pend_a), 8'h00);
    chk("ack2_irq", 8'(irq_a), 8'h00);
    steps(5);
    // simultaneous edges, ack, then an erroneous re-ack
    req_in = 4'b1010;
    steps(4);
    chk("dual", 8'(pend_b), 8'h0a);
    do_ack(2'd3);
    chk("ack3", 8'(pend_a), 8'h02);
    do_ack(2'd3);
    chk("ackerr", 8'(err_a), 8'h01);
    chk("ackerr_pend", 8'(pend_a), 8'h02);
    step();
    chk("ackerr_pulse", 8'(err_a), 8'h00);
    req_in = 4'b0000;
    do_ack(2'd1);
    steps(4);
    // overrun on line 0, clear, then an edge coinciding with an ack of line 0 on depth 2
    req_in = 4'b0001; steps(2); req_in = 4'b0000; steps(5);
    req_in = 4'b0001; steps(2); req_in = 4'b0000; steps(5);
    chk("ovr", 8'(ovr_a), 8'h01);
    clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
    chk("ovr_clr", 8'(ovr_a), 8'h00);
    req_in = 4'b0001; steps(2);
    do_ack(2'd0);
    chk("coinc_pend", 8'(pend_a[0]), 8'h01);
    chk("coinc_ovr", 8'(ovr_a), 8'h00);
    req_in = 4'b0000; steps(5);
    // masking hides but keeps the event; ack while masked raises no error
    mask_wr = 1'b1; mask_din = 4'b0001; step(); mask_wr = 1'b0;
    chk("mask_pend", 8'(pend_a), 8'h00);
    chk("mask_irq", 8'(irq_a), 8'h00);
    mask_wr = 1'b1; mask_din = 4'b0000; step();
    chk("unmask", 8'(pend_a), 8'h01);
    mask_din = 4'b0001; step(); mask_wr = 1'b0;
    do_ack(2'd0);
    chk("mack_err", 8'(err_a), 8'h00);
    mask_wr = 1'b1; mask_din = 4'b0000; step(); mask_wr = 1'b0;
    chk("mack_pend", 8'(pend_a), 8'h00);
    // async reset with line 1 held high: one fresh event after release
    req_in = 4'b0010; steps(5);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("arst_pend", 8'(pend_a), 8'h00);
    chk("arst_irq", 8'(irq_b), 8'h00);
    #1 rst = 1'b0;
    steps(2);
    chk("rel_early", 8'(pend_a), 8'h00);
    step();
    chk("rel_pend", 8'(pend_a), 8'h02);
    do_ack(2'd1);
    do_ack(2'd1);
    steps(6);
    chk("held_once", 8'(pend_b), 8'h00);
    // random phase against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) req_in = 4'($urandom);
      ack = ($urandom_range(0, 2) == 0);
      ack_idx = 2'($urandom);
      mask_wr = ($urandom_range(0, 9) == 0);
      mask_din = 4'($urandom);
      clr_overrun = ($urandom_range(0, 14) == 0);
      step("rnd");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
